// File: rtl/glc_pkg.sv
// Shared definitions for the grant lock controller: channel count, index
// width, watchdog default and the FSM state encoding.
package glc_pkg;

   localparam int unsigned N          = 16;
   localparam int unsigned IDXW       = 4;
   localparam int unsigned CNTW       = 8;
   localparam int unsigned TO_CYC_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOCK = 2'd1,
      ST_BUSY = 2'd2,
      ST_REL  = 2'd3
   } glc_state_t;

endpackage

// File: rtl/onehot_enc16.sv
// One-hot classifier and binary encoder for a 16-bit vector.
// Ports:
//   vec      in   16  vector to classify
//   is_one   out  1   exactly one bit set
//   is_multi out  1   two or more bits set
//   idx      out  4   position of the highest set bit (meaningful when is_one)
module onehot_enc16
   import glc_pkg::*;
(
   input  logic [N-1:0]    vec,
   output logic            is_one,
   output logic            is_multi,
   output logic [IDXW-1:0] idx
);

   logic [N-1:0] vec_m1;

   // Clearing the lowest set bit leaves something only if more than one bit was set.
   assign vec_m1   = N'(vec - N'(1));
   assign is_multi = (vec & vec_m1) != '0;
   assign is_one   = (vec != '0) && !is_multi;

   // Priority encoder; for a one-hot input this is the plain binary index.
   always_comb begin
      idx = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (vec[i]) idx = IDXW'(i);
      end
   end

endmodule

// File: rtl/grant_lock_ctrl16.sv
// Grant lock controller downstream of a 16-channel priority arbiter.
// Captures a one-hot grant, holds it for one transaction on the shared
// resource, pulses svc_start when the transaction is launched and ack to the
// serviced channel when it completes, then releases for one idle cycle.
// Optional build macro GLC_TIMEOUT_EN adds a BUSY watchdog (parameter TO_CYC)
// and the to_flag output.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req[15:0]     raw request vector
//   gnt_in[15:0]  arbiter grant (expected one-hot)
//   svc_ready     resource can accept a transaction
//   svc_done      resource finished the current transaction
//   lock_valid    a channel is locked
//   lock_gnt      locked one-hot grant, 0 when unlocked
//   lock_idx      binary index of locked channel, 0 when unlocked
//   svc_start     launch pulse, asserted in the LOCK cycle that hands off
//   ack           one-cycle one-hot completion pulse
//   err_mh        sticky multi-hot grant error
//   to_flag       watchdog expiry pulse (GLC_TIMEOUT_EN only)
module grant_lock_ctrl16
   import glc_pkg::*;
`ifdef GLC_TIMEOUT_EN
#(
   parameter int unsigned TO_CYC = TO_CYC_DEF
)
`endif
(
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    gnt_in,
   input  logic            svc_ready,
   input  logic            svc_done,
   output logic            lock_valid,
   output logic [N-1:0]    lock_gnt,
   output logic [IDXW-1:0] lock_idx,
   output logic            svc_start,
   output logic [N-1:0]    ack,
`ifdef GLC_TIMEOUT_EN
   output logic            to_flag,
`endif
   output logic            err_mh
);

   glc_state_t      state;
   logic            gi_one;
   logic            gi_multi;
   logic [IDXW-1:0] gi_idx;
   logic            withdraw;

`ifdef GLC_TIMEOUT_EN
   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_nxt;
   assign cnt_nxt = CNTW'(cnt + CNTW'(1));
`endif

   onehot_enc16 u_gnt_enc (
      .vec      (gnt_in),
      .is_one   (gi_one),
      .is_multi (gi_multi),
      .idx      (gi_idx)
   );

   assign withdraw = !req[lock_idx];

   // Launch happens in the LOCK cycle itself so BUSY can sample svc_done on
   // its very first cycle; a same-cycle withdraw suppresses it.
   assign svc_start = !rst && (state == ST_LOCK) && !withdraw && svc_ready;

   // Lock FSM with registered lock/ack outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         lock_valid <= 1'b0;
         lock_gnt   <= '0;
         lock_idx   <= '0;
         ack        <= '0;
         err_mh     <= 1'b0;
`ifdef GLC_TIMEOUT_EN
         cnt        <= '0;
         to_flag    <= 1'b0;
`endif
      end else begin
         ack <= '0;
`ifdef GLC_TIMEOUT_EN
         to_flag <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               // gnt_in is only trusted while something is requesting.
               if (req != '0) begin
                  if (gi_multi) begin
                     err_mh <= 1'b1;
                  end else if (gi_one && ((gnt_in & req) != '0)) begin
                     state      <= ST_LOCK;
                     lock_valid <= 1'b1;
                     lock_gnt   <= gnt_in;
                     lock_idx   <= gi_idx;
                  end
               end
            end
            ST_LOCK: begin
               if (withdraw) begin
                  state      <= ST_IDLE;
                  lock_valid <= 1'b0;
                  lock_gnt   <= '0;
                  lock_idx   <= '0;
               end else if (svc_ready) begin
                  state <= ST_BUSY;
`ifdef GLC_TIMEOUT_EN
                  cnt   <= '0;
`endif
               end
            end
            ST_BUSY: begin
               if (svc_done) begin
                  state      <= ST_REL;
                  ack        <= lock_gnt;
                  lock_valid <= 1'b0;
                  lock_gnt   <= '0;
                  lock_idx   <= '0;
`ifdef GLC_TIMEOUT_EN
               end else if (cnt_nxt == CNTW'(TO_CYC)) begin
                  state      <= ST_REL;
                  to_flag    <= 1'b1;
                  lock_valid <= 1'b0;
                  lock_gnt   <= '0;
                  lock_idx   <= '0;
               end else begin
                  cnt <= cnt_nxt;
`endif
               end
            end
            ST_REL: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grant_lock_ctrl16.sv
// Directed testbench for grant_lock_ctrl16. Inputs change 1 ns after the
// rising edge; outputs are checked in the same window.
module tb_grant_lock_ctrl16;

   logic        clk;
   logic        rst;
   logic [15:0] req;
   logic [15:0] gnt_in;
   logic        svc_ready;
   logic        svc_done;
   logic        lock_valid;
   logic [15:0] lock_gnt;
   logic [3:0]  lock_idx;
   logic        svc_start;
   logic [15:0] ack;
   logic        err_mh;
`ifdef GLC_TIMEOUT_EN
   logic        to_flag;
`endif

   int total = 0;
   int bad   = 0;

`ifdef GLC_TIMEOUT_EN
   grant_lock_ctrl16 #(.TO_CYC(5)) dut (
`else
   grant_lock_ctrl16 dut (
`endif
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .gnt_in     (gnt_in),
      .svc_ready  (svc_ready),
      .svc_done   (svc_done),
      .lock_valid (lock_valid),
      .lock_gnt   (lock_gnt),
      .lock_idx   (lock_idx),
      .svc_start  (svc_start),
      .ack        (ack),
`ifdef GLC_TIMEOUT_EN
      .to_flag    (to_flag),
`endif
      .err_mh     (err_mh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; gnt_in = '0; svc_ready = 1'b0; svc_done = 1'b0;
      step(); step();
      total++;
      if ({lock_valid, lock_gnt, lock_idx, svc_start, ack, err_mh} !== 39'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", {lock_valid, lock_gnt, lock_idx, svc_start, ack, err_mh});
      end
      rst = 1'b0;
      step();
   endtask

   // Channel 15 with immediate ready, done one cycle into BUSY.
   task automatic test_basic();
      req = 16'h8001; gnt_in = 16'h8000; svc_ready = 1'b1; svc_done = 1'b0;
      step();
      total++;
      if ({lock_valid, lock_gnt, lock_idx, svc_start} !== {1'b1, 16'h8000, 4'd15, 1'b1}) begin
         bad++;
         $display("FAIL basic_lock got=%h want=%h", {lock_valid, lock_gnt, lock_idx, svc_start}, {1'b1, 16'h8000, 4'd15, 1'b1});
      end
      step();
      total++;
      if ({lock_valid, svc_start, ack} !== {1'b1, 1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL basic_busy got=%h want=%h", {lock_valid, svc_start, ack}, {1'b1, 1'b0, 16'h0000});
      end
      svc_done = 1'b1;
      step();
      total++;
      if ({lock_valid, lock_gnt, lock_idx, ack} !== {1'b0, 16'h0000, 4'd0, 16'h8000}) begin
         bad++;
         $display("FAIL basic_rel got=%h want=%h", {lock_valid, lock_gnt, lock_idx, ack}, {1'b0, 16'h0000, 4'd0, 16'h8000});
      end
      svc_done = 1'b0; req = '0; gnt_in = '0;
      step();
      total++;
      if ({lock_valid, ack, svc_start} !== 18'd0) begin
         bad++;
         $display("FAIL basic_idle got=%h want=0", {lock_valid, ack, svc_start});
      end
   endtask

   task automatic test_no_req();
      req = '0; gnt_in = 16'hxxxx; svc_ready = 1'b1;
      step(); step();
      total++;
      if ({lock_valid, svc_start, err_mh} !== 3'b000) begin
         bad++;
         $display("FAIL noreq got=%b want=000", {lock_valid, svc_start, err_mh});
      end
      gnt_in = '0; svc_ready = 1'b0;
   endtask

   task automatic test_zero_or_foreign_gnt();
      req = 16'h0100; gnt_in = 16'h0000;
      step();
      total++;
      if (lock_valid !== 1'b0) begin
         bad++;
         $display("FAIL zero_gnt got=%b want=0", lock_valid);
      end
      gnt_in = 16'h0001;
      step();
      total++;
      if ({lock_valid, err_mh} !== 2'b00) begin
         bad++;
         $display("FAIL foreign_gnt got=%b want=00", {lock_valid, err_mh});
      end
      req = '0; gnt_in = '0;
   endtask

   task automatic test_multihot();
      req = 16'h0030; gnt_in = 16'h0030;
      step();
      total++;
      if ({err_mh, lock_valid} !== 2'b10) begin
         bad++;
         $display("FAIL mh_set got=%b want=10", {err_mh, lock_valid});
      end
      req = '0; gnt_in = '0;
      step(); step();
      total++;
      if (err_mh !== 1'b1) begin
         bad++;
         $display("FAIL mh_sticky got=%b want=1", err_mh);
      end
   endtask

   // Lock channel 4, then withdraw in the same cycle ready rises.
   task automatic test_withdraw();
      req = 16'h0010; gnt_in = 16'h0010; svc_ready = 1'b0;
      step();
      total++;
      if ({lock_valid, lock_idx, svc_start} !== {1'b1, 4'd4, 1'b0}) begin
         bad++;
         $display("FAIL wd_lock got=%h want=%h", {lock_valid, lock_idx, svc_start}, {1'b1, 4'd4, 1'b0});
      end
      req = 16'h0001; svc_ready = 1'b1;
      #1;
      total++;
      if (svc_start !== 1'b0) begin
         bad++;
         $display("FAIL wd_nostart got=%b want=0", svc_start);
      end
      gnt_in = '0; req = '0;
      step();
      total++;
      if ({lock_valid, lock_gnt, lock_idx, ack, svc_start} !== 38'd0) begin
         bad++;
         $display("FAIL wd_idle got=%h want=0", {lock_valid, lock_gnt, lock_idx, ack, svc_start});
      end
      step();
      total++;
      if (ack !== 16'h0000) begin
         bad++;
         $display("FAIL wd_noack got=%h want=0000", ack);
      end
      svc_ready = 1'b0;
   endtask

   // Channel 9 twice back to back; gnt_in/req noise in BUSY must be ignored.
   task automatic test_back_to_back();
      req = 16'h0200; gnt_in = 16'h0200; svc_ready = 1'b1; svc_done = 1'b1;
      step();
      total++;
      if ({lock_valid, lock_idx, svc_start} !== {1'b1, 4'd9, 1'b1}) begin
         bad++;
         $display("FAIL b2b_lock1 got=%h want=%h", {lock_valid, lock_idx, svc_start}, {1'b1, 4'd9, 1'b1});
      end
      gnt_in = 16'h8000;
      step();
      total++;
      if ({lock_gnt, ack} !== {16'h0200, 16'h0000}) begin
         bad++;
         $display("FAIL b2b_busy got=%h want=%h", {lock_gnt, ack}, {16'h0200, 16'h0000});
      end
      gnt_in = 16'h0200;
      step();
      total++;
      if ({lock_valid, ack} !== {1'b0, 16'h0200}) begin
         bad++;
         $display("FAIL b2b_ack1 got=%h want=%h", {lock_valid, ack}, {1'b0, 16'h0200});
      end
      step();
      total++;
      if ({lock_valid, ack} !== 17'd0) begin
         bad++;
         $display("FAIL b2b_gap got=%h want=0", {lock_valid, ack});
      end
      step();
      total++;
      if ({lock_valid, lock_idx, svc_start} !== {1'b1, 4'd9, 1'b1}) begin
         bad++;
         $display("FAIL b2b_lock2 got=%h want=%h", {lock_valid, lock_idx, svc_start}, {1'b1, 4'd9, 1'b1});
      end
      step(); step();
      total++;
      if (ack !== 16'h0200) begin
         bad++;
         $display("FAIL b2b_ack2 got=%h want=0200", ack);
      end
      req = '0; gnt_in = '0; svc_ready = 1'b0; svc_done = 1'b0;
      step();
   endtask

   // Channel 0 held in BUSY for a few cycles while req drops.
   task automatic test_busy_hold();
      req = 16'h0001; gnt_in = 16'h0001; svc_ready = 1'b1; svc_done = 1'b0;
      step(); step();
      req = '0; gnt_in = 16'h0004; svc_ready = 1'b0;
      step(); step(); step();
      total++;
      if ({lock_valid, lock_gnt, lock_idx, ack} !== {1'b1, 16'h0001, 4'd0, 16'h0000}) begin
         bad++;
         $display("FAIL hold_busy got=%h want=%h", {lock_valid, lock_gnt, lock_idx, ack}, {1'b1, 16'h0001, 4'd0, 16'h0000});
      end
      svc_done = 1'b1;
      step();
      total++;
      if (ack !== 16'h0001) begin
         bad++;
         $display("FAIL hold_ack got=%h want=0001", ack);
      end
      svc_done = 1'b0; gnt_in = '0;
      step();
   endtask

   task automatic test_reset_in_busy();
      req = 16'h0004; gnt_in = 16'h0004; svc_ready = 1'b1; svc_done = 1'b0;
      step(); step();
      rst = 1'b1; svc_done = 1'b1;
      step();
      total++;
      if ({lock_valid, lock_gnt, lock_idx, svc_start, ack, err_mh} !== 39'd0) begin
         bad++;
         $display("FAIL rstbusy_out got=%h want=0", {lock_valid, lock_gnt, lock_idx, svc_start, ack, err_mh});
      end
      rst = 1'b0; svc_done = 1'b0; req = '0; gnt_in = '0; svc_ready = 1'b0;
      step();
      total++;
      if ({lock_valid, ack} !== 17'd0) begin
         bad++;
         $display("FAIL rstbusy_after got=%h want=0", {lock_valid, ack});
      end
   endtask

`ifdef GLC_TIMEOUT_EN
   task automatic test_timeout();
      req = 16'h0040; gnt_in = 16'h0040; svc_ready = 1'b1; svc_done = 1'b0;
      step(); step();
      svc_ready = 1'b0;
      for (int i = 1; i <= 4; i++) step();
      total++;
      if ({to_flag, lock_valid} !== 2'b01) begin
         bad++;
         $display("FAIL to_before got=%b want=01", {to_flag, lock_valid});
      end
      step();
      total++;
      if ({to_flag, lock_valid, ack} !== {1'b1, 1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL to_fire got=%h want=%h", {to_flag, lock_valid, ack}, {1'b1, 1'b0, 16'h0000});
      end
      step();
      total++;
      if ({to_flag, lock_valid} !== 2'b00) begin
         bad++;
         $display("FAIL to_after got=%b want=00", {to_flag, lock_valid});
      end
      // Done on the limit cycle beats the watchdog.
      svc_ready = 1'b1;
      step(); step();
      svc_ready = 1'b0;
      for (int i = 1; i <= 4; i++) step();
      svc_done = 1'b1;
      step();
      total++;
      if ({to_flag, ack} !== {1'b0, 16'h0040}) begin
         bad++;
         $display("FAIL to_done_wins got=%h want=%h", {to_flag, ack}, {1'b0, 16'h0040});
      end
      svc_done = 1'b0; req = '0; gnt_in = '0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_no_req();
      test_zero_or_foreign_gnt();
      test_multihot();
      test_withdraw();
      test_back_to_back();
      test_busy_hold();
      test_reset_in_busy();
`ifdef GLC_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
